// File: rtl/smartac_fan_pwm.sv
// rtl/smartac_fan_pwm.sv - ramped, period-latched PWM fan drive with ramp/at-speed status
module smartac_fan_pwm #(
    parameter int PERIOD   = 100,
    parameter int RAMP_DIV = 4,
    parameter int STEP     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SW,
    input  logic [2:0] fan_level,
    output logic       pwm_out,
    output logic [7:0] duty_now,
    output logic       ramping,
    output logic       at_speed
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [7:0]    QUARTER = 8'(PERIOD / 4);
    localparam logic [7:0]    STEP8   = 8'(STEP);
    localparam logic [7:0]    CNT_END = 8'(PERIOD - 1);
    localparam logic [PW-1:0] PC_END  = PW'(RAMP_DIV - 1);

    state_t        state, state_next;
    logic [7:0]    cnt, duty_reg, target, diff, delta, duty_next;
    logic [2:0]    level;
    logic [PW-1:0] pcnt;
    logic          pe, moving, step;

    assign level    = (fan_level > 3'd4) ? 3'd4 : fan_level;
    assign target   = SW ? 8'(level) * QUARTER : 8'd0;
    assign pe       = (cnt == CNT_END);
    assign moving   = (state == UP) || (state == DOWN);
    assign step     = pe && moving && (pcnt == PC_END);
    assign ramping  = moving;
    assign at_speed = (state == HOLD);

    // Step size is clamped to the remaining distance, so the ramp can never overshoot.
    always_comb begin
        diff      = (target >= duty_now) ? (target - duty_now) : (duty_now - target);
        delta     = (diff < STEP8) ? diff : STEP8;
        duty_next = duty_now;
        if (step) begin
            duty_next = (target > duty_now) ? (duty_now + delta) : (duty_now - delta);
        end
    end

    always_comb begin
        state_next = state;
        if (duty_next == target) begin
            state_next = (target == 8'd0) ? IDLE : HOLD;
        end else if (duty_next < target) begin
            state_next = UP;
        end else begin
            state_next = DOWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // pcnt only advances while ramping, so a reversal keeps its divider phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 8'd0;
            pcnt     <= '0;
            duty_now <= 8'd0;
            duty_reg <= 8'd0;
            pwm_out  <= 1'b0;
        end else begin
            cnt      <= pe ? 8'd0 : cnt + 8'd1;
            duty_now <= duty_next;
            pwm_out  <= (cnt < duty_reg);
            if (pe) begin
                duty_reg <= duty_next;
            end
            if (!moving) begin
                pcnt <= '0;
            end else if (pe) begin
                pcnt <= (pcnt == PC_END) ? '0 : pcnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/smartac_fan_pwm.md
Name: smartac_fan_pwm

Overview:
- Downstream stage of the SmartAC mode/fan controller.
- Consumes its fan speed level (0..4) and on/off switch, and produces a glitch-free PWM drive for the fan motor.
- Speed changes ramp at a fixed rate instead of stepping, so motor inrush and acoustic jumps stay bounded.
- Reports ramp/at-speed status to the display logic.

Parameters:
PERIOD, 100, PWM period in clocks; multiple of 4, range 4..252.
RAMP_DIV, 4, PWM periods per ramp step; at least 1.
STEP, 5, duty change per ramp step in clocks; range 1..PERIOD.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
SW  input  1  system on/off; 0 forces target duty to 0 (ramped, not instant)
fan_level  input  3  requested speed 0..4 from fan controller, synchronous to clk; values 5..7 treated as 4
pwm_out  output  1  registered PWM motor drive
duty_now  output  8  current ramped duty in clocks, 0..PERIOD
ramping  output  1  high while duty_now != target
at_speed  output  1  high when duty_now == target and target != 0

Behaviour:
- Reset (async assert, sync release): all registers 0; state IDLE; pwm_out=0, duty_now=0, ramping=0, at_speed=0.
- Target: target = SW ? min(fan_level,4)*PERIOD/4 : 0, evaluated combinationally each cycle.
  - PERIOD=100 gives targets 0/25/50/75/100.
- Period counter cnt: free-running 0..PERIOD-1, wraps to 0.
  - Period end (PE) = the cycle with cnt==PERIOD-1.
- Ramp divider pcnt: 0..RAMP_DIV-1.
  - Increments at each PE while in UP or DOWN.
  - Held at 0 in IDLE and HOLD.
  - Step fires at a PE with pcnt==RAMP_DIV-1; pcnt then wraps to 0.
- Step rule:
  - duty_now moves toward target by min(STEP, |target-duty_now|).
  - It never overshoots and never leaves 0..PERIOD.
- Duty latch: duty_reg loads the post-step duty_now at every PE.
  - New duty takes effect from the next cnt=0.
  - Mid-period changes never alter the current period.
- PWM: pwm_out <= (cnt < duty_reg), registered, so pwm_out lags cnt by one cycle.
  - duty_reg=0 gives constant 0; duty_reg=PERIOD gives constant 1.
- State machine (registered; next state from duty_now vs target):
  - IDLE: duty_now==0 and target==0.
  - UP: duty_now < target.
  - DOWN: duty_now > target.
  - HOLD: duty_now==target!=0.
- Transitions:
  - IDLE->UP on nonzero target.
  - UP->HOLD when the final step lands on target.
  - HOLD->UP or HOLD->DOWN on a target change.
  - DOWN->IDLE when duty_now reaches 0.
  - UP<->DOWN directly on target reversal mid-ramp, without resetting pcnt.
- Status outputs: ramping=1 in UP/DOWN; at_speed=1 in HOLD only.
- Leaving IDLE/HOLD: the first step occurs at the RAMP_DIV-th PE after the target change.
- SW drop mid-ramp or in HOLD: target becomes 0 immediately; duty ramps down at the normal rate.
- Target change on the same cycle as a step: the step uses the new target.
- rst_n asserted mid-operation: pwm_out drops to 0 asynchronously; all state clears. After release, cnt restarts at 0.

Test Plan (defaults PERIOD=100, RAMP_DIV=4, STEP=5):
1. Reset, SW=1, fan_level 0->4 → duty_now rises 0,5,...,100 in steps every 400 clocks; ramping=1 throughout; at_speed=1 after the 20th step; pwm_out then constant 1.
2. HOLD at level 2 (duty 50) → pwm_out high for exactly 50 of every 100 clocks, 1-cycle lag after cnt=0; ramping=0, at_speed=1.
3. Level 4->1 → duty_now falls 100->25 in 15 steps; state DOWN then HOLD; each period's high time matches duty_reg latched at the prior PE.
4. STEP=30, ramp 0->25 then 25->100 → first ramp reaches 25 in one clamped step; second ramp goes 55, 85, 100; no overshoot.
5. SW 1->0 while at duty 75 → target 0; ramps to 0 over 15 steps; ends in IDLE with pwm_out=0; at_speed=0 throughout.
6. Reversal 0->4 then back to 0 at duty_now=40, plus mid-period rst_n pulse → direction reverses at the next step with no pcnt restart; on reset, pwm_out goes 0 asynchronously and duty_now=0; fan_level=7 behaves as 4.
